interrupt_controller: RTL and testbench

//   Sequences hardware interrupt entry and return for the 5-stage pipeline.

---
 rtl/interrupt_controller_pkg.sv | 17 +
 rtl/interrupt_controller.sv | 131 +++++++++++++
 tb/tb_interrupt_controller.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared pipeline definitions for the interrupt entry/return sequencer.
package interrupt_controller_pkg;

    localparam int CPU_PC_W   = 32;
    localparam int CPU_DATA_W = 16;
    localparam int CPU_FLAG_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_PUSH_HI = 3'd2,
        ST_PUSH_LO = 3'd3,
        ST_VECTOR  = 3'd4,
        ST_IN_ISR  = 3'd5
    } state_e;

endpackage

// File: rtl/interrupt_controller.sv
// Interrupt entry/return sequencer: drains the front end, pushes the resume PC
// as two stack halves, vectors fetch to the ISR and restores flags on RTI.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int              PC_W         = CPU_PC_W,
    parameter int              DATA_W       = CPU_DATA_W,
    parameter int              FLAG_W       = CPU_FLAG_W,
    parameter logic [PC_W-1:0] ISR_PC       = 32'h0000_0100,
    parameter int              DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              int_req,
    input  logic              pipe_busy,
    input  logic [PC_W-1:0]   resume_pc,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic              rti_commit,
    output logic              if_flush,
    output logic              id_flush,
    output logic              pc_stall,
    output logic              pc_sel_int,
    output logic [PC_W-1:0]   isr_pc,
    output logic              int_mem_sel1,
    output logic              int_mem_sel2,
    output logic [DATA_W-1:0] push_data,
    output logic              dec_sp,
    output logic              flags_restore,
    output logic [FLAG_W-1:0] flags_out,
    output logic              int_active
);

    state_e            state_q, state_d;
    logic              int_req_q;
    logic              pending_q, pending_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [PC_W-1:0]   saved_pc_q, saved_pc_d;
    logic [FLAG_W-1:0] saved_flags_q, saved_flags_d;
    logic              req_edge;

    assign req_edge = int_req & ~int_req_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            int_req_q     <= 1'b0;
            pending_q     <= 1'b0;
            cnt_q         <= '0;
            saved_pc_q    <= '0;
            saved_flags_q <= '0;
        end else begin
            state_q       <= state_d;
            int_req_q     <= int_req;
            pending_q     <= pending_d;
            cnt_q         <= cnt_d;
            saved_pc_q    <= saved_pc_d;
            saved_flags_q <= saved_flags_d;
        end
    end

    // One-deep request latch: a new edge always wins over the clear at VECTOR.
    always_comb begin
        pending_d = pending_q;
        if (state_q == ST_VECTOR) pending_d = 1'b0;
        if (req_edge)             pending_d = 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        saved_pc_d    = saved_pc_q;
        saved_flags_d = saved_flags_q;
        if_flush      = 1'b0;
        id_flush      = 1'b0;
        pc_stall      = 1'b0;
        pc_sel_int    = 1'b0;
        int_mem_sel1  = 1'b0;
        int_mem_sel2  = 1'b0;
        push_data     = '0;
        dec_sp        = 1'b0;
        flags_restore = 1'b0;
        int_active    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q && !pipe_busy) begin
                    state_d       = ST_DRAIN;
                    saved_pc_d    = resume_pc;
                    saved_flags_d = flags_in;
                    cnt_d         = 4'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if_flush = 1'b1;
                id_flush = 1'b1;
                pc_stall = 1'b1;
                if (cnt_q == '0) state_d = ST_PUSH_HI;
                else             cnt_d   = cnt_q - 4'd1;
            end
            ST_PUSH_HI: begin
                int_mem_sel1 = 1'b1;
                dec_sp       = 1'b1;
                pc_stall     = 1'b1;
                push_data    = saved_pc_q[PC_W-1 -: DATA_W];
                state_d      = ST_PUSH_LO;
            end
            ST_PUSH_LO: begin
                int_mem_sel2 = 1'b1;
                dec_sp       = 1'b1;
                pc_stall     = 1'b1;
                push_data    = saved_pc_q[DATA_W-1:0];
                state_d      = ST_VECTOR;
            end
            ST_VECTOR: begin
                pc_sel_int = 1'b1;
                state_d    = ST_IN_ISR;
            end
            ST_IN_ISR: begin
                int_active = 1'b1;
                if (rti_commit) begin
                    flags_restore = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign isr_pc    = ISR_PC;
    assign flags_out = saved_flags_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed plus randomized bench for interrupt_controller against a
// cycle-position reference model of the entry/return sequence.
module tb_interrupt_controller;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset, int_req, pipe_busy, rti_commit;
    logic [31:0] resume_pc;
    logic [3:0]  flags_in;
    logic        if_flush, id_flush, pc_stall, pc_sel_int;
    logic [31:0] isr_pc;
    logic        int_mem_sel1, int_mem_sel2, dec_sp, flags_restore, int_active;
    logic [15:0] push_data;
    logic [3:0]  flags_out;

    int checks = 0;
    int errors = 0;

    // Model: pos = -1 idle, 0..D-1 drain, D push hi, D+1 push lo, D+2 vector, D+3 in ISR.
    int          pos;
    bit          m_pend, m_prev;
    logic [31:0] m_pc;
    logic [3:0]  m_fl;

    interrupt_controller #(.DRAIN_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .int_req(int_req), .pipe_busy(pipe_busy),
        .resume_pc(resume_pc), .flags_in(flags_in), .rti_commit(rti_commit),
        .if_flush(if_flush), .id_flush(id_flush), .pc_stall(pc_stall),
        .pc_sel_int(pc_sel_int), .isr_pc(isr_pc), .int_mem_sel1(int_mem_sel1),
        .int_mem_sel2(int_mem_sel2), .push_data(push_data), .dec_sp(dec_sp),
        .flags_restore(flags_restore), .flags_out(flags_out), .int_active(int_active)
    );

    always #5 clk = ~clk;

    function automatic logic [60:0] dutv();
        return {if_flush, id_flush, pc_stall, pc_sel_int, int_mem_sel1, int_mem_sel2,
                dec_sp, flags_restore, int_active, push_data, flags_out, isr_pc};
    endfunction

    function automatic logic [60:0] expv();
        bit          drn;
        logic [15:0] pd;
        drn = (pos >= 0) && (pos < D);
        pd  = (pos == D) ? m_pc[31:16] : (pos == D + 1) ? m_pc[15:0] : 16'h0;
        return {drn, drn, (pos >= 0) && (pos <= D + 1), pos == D + 2, pos == D, pos == D + 1,
                (pos == D) || (pos == D + 1), (pos == D + 3) && rti_commit, pos == D + 3,
                pd, m_fl, 32'h0000_0100};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pos = -1; m_pend = 0; m_prev = 0; m_pc = '0; m_fl = '0;
    endtask

    task automatic model_step();
        bit edge_r;
        int old;
        if (reset) begin
            model_reset();
            return;
        end
        edge_r = int_req && !m_prev;
        old    = pos;
        if (pos == -1) begin
            if (m_pend && !pipe_busy) begin
                pos = 0; m_pc = resume_pc; m_fl = flags_in;
            end
        end else if (pos < D + 3) begin
            pos++;
        end else if (rti_commit) begin
            pos = -1;
        end
        if (edge_r)              m_pend = 1;
        else if (old == D + 2)   m_pend = 0;
        m_prev = int_req;
    endtask

    // Compare on the falling edge, advance the model on the rising edge, return just after it.
    task automatic cycle(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("outs", {3'b0, dutv()}, {3'b0, expv()});
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    initial begin
        reset = 1; int_req = 0; pipe_busy = 0; rti_commit = 0;
        resume_pc = '0; flags_in = '0;
        model_reset();
        #1;
        chk("rst_outs", {3'b0, dutv()}, {32'b0, 32'h0000_0100});
        cycle(2);
        reset = 0;

        // basic entry
        resume_pc = 32'h0001_0040; flags_in = 4'b1010; int_req = 1;
        cycle(2);
        chk("t2_drain", {61'b0, if_flush, id_flush, pc_stall}, 64'h7);
        resume_pc = 32'hDEAD_BEEF; flags_in = 4'b0101;
        cycle(2);
        chk("t2_hi", {46'b0, int_mem_sel1, dec_sp, push_data}, {46'b0, 2'b11, 16'h0001});
        cycle(1);
        chk("t2_lo", {46'b0, int_mem_sel2, dec_sp, push_data}, {46'b0, 2'b11, 16'h0040});
        cycle(1);
        chk("t2_vec", {31'b0, pc_sel_int, isr_pc}, {31'b0, 1'b1, 32'h0000_0100});
        cycle(1);
        chk("t2_active", {63'b0, int_active}, 64'h1);
        cycle(3);
        // RTI restore
        rti_commit = 1; #1;
        chk("t4_restore", {59'b0, flags_restore, flags_out}, {59'b0, 1'b1, 4'b1010});
        cycle(1);
        rti_commit = 0;
        chk("t4_idle", {62'b0, int_active, flags_restore}, 64'h0);
        int_req = 0;
        cycle(2);

        // reset in the middle of PUSH_LO
        resume_pc = 32'h1234_5678; int_req = 1;
        cycle(1 + 1 + D + 1);
        chk("t1_in_lo", {63'b0, int_mem_sel2}, 64'h1);
        #2; reset = 1; #1;
        model_reset();
        chk("t1_async", {3'b0, dutv()}, {32'b0, 32'h0000_0100});
        int_req = 0;
        cycle(1);
        reset = 0;
        cycle(3);
        chk("t1_no_decsp", {63'b0, dec_sp}, 64'h0);

        // deferred by pipe_busy
        pipe_busy = 1; int_req = 1;
        cycle(3);
        chk("t3_wait", {63'b0, if_flush}, 64'h0);
        resume_pc = 32'hCAFE_0010; pipe_busy = 0;
        cycle(1);
        resume_pc = 32'h0;
        cycle(D);
        chk("t3_pc_hi", {48'b0, push_data}, 64'hCAFE);
        cycle(4);

        // nested requests during ISR: one replays, the extra edge is dropped
        int_req = 0; cycle(1);
        int_req = 1; cycle(1);
        int_req = 0; cycle(1);
        int_req = 1; cycle(1);
        rti_commit = 1; cycle(1);
        rti_commit = 0;
        cycle(D + 5);
        chk("t5_replay", {63'b0, int_active}, 64'h1);
        rti_commit = 1; cycle(1);
        rti_commit = 0;
        cycle(6);
        chk("t5_no_extra", {61'b0, if_flush, dec_sp, int_active}, 64'h0);

        // level held high: single entry; RTI while idle is ignored
        int_req = 0; cycle(1);
        int_req = 1;
        cycle(10);
        rti_commit = 1; cycle(1);
        rti_commit = 0;
        cycle(9);
        rti_commit = 1; #1;
        chk("t6_idle_rti", {63'b0, flags_restore}, 64'h0);
        cycle(1);
        rti_commit = 0; int_req = 0;
        cycle(2);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) int_req = ~int_req;
            pipe_busy  = ($urandom_range(0, 3) == 0);
            rti_commit = (pos == D + 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 19) == 0);
            resume_pc  = $urandom;
            flags_in   = 4'($urandom);
            reset      = ($urandom_range(0, 399) == 0);
            if (reset) begin
                #1;
                model_reset();
            end
            cycle(1);
            reset = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
